// File: rtl/vga_fb_arbiter_pkg.sv
// Shared definitions for the VGA framebuffer arbiter.
// Holds the 640x480 raster timing totals, the framebuffer depth, the bus widths,
// and the encoding of the single RAM port's per-cycle operation.
package vga_fb_pkg;

    localparam int H_TOTAL  = 800;
    localparam int H_ACTIVE = 640;
    localparam int V_TOTAL  = 525;
    localparam int V_ACTIVE = 480;
    localparam int FB_DEPTH = 19200;

    localparam int ADDR_W  = 15;
    localparam int COLOR_W = 12;
    localparam int COORD_W = 10;
    localparam int ROW_W   = 7;
    localparam int COL_W   = 8;

    // What the RAM port is doing in a given cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISP_RD = 2'd1,
        WRITE   = 2'd2
    } port_state_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Writer request channel plus single-port framebuffer RAM bus.
//   wr_valid/wr_addr/wr_data : pixel write request from the drawing side
//   wr_ready                 : arbiter can accept the request this cycle
//   mem_en/mem_we/mem_addr/mem_wdata : RAM command, registered by the arbiter
//   mem_rdata                : RAM read data, one cycle after a read command
// master: the arbiter. slave: the writer and the RAM.
interface vga_fb_arbiter_if;
    import vga_fb_pkg::*;

    logic                 wr_valid;
    logic [ADDR_W-1:0]    wr_addr;
    logic [COLOR_W-1:0]   wr_data;
    logic                 wr_ready;

    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [COLOR_W-1:0]   mem_wdata;
    logic [COLOR_W-1:0]   mem_rdata;

    modport master (
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/vga_fb_arbiter_fb_addr_calc.sv
// Framebuffer address from (row, col): addr = row * FB_W + col.
//   row  : stored-pixel row
//   col  : stored-pixel column
//   addr : linear 15-bit RAM address
// Purely combinational.
module fb_addr_calc
    import vga_fb_pkg::*;
#(
    parameter int FB_W = 160
) (
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] row_ext;
    logic [ADDR_W-1:0] col_ext;
    logic [ADDR_W-1:0] row_base;

    assign row_ext = ADDR_W'(row);
    assign col_ext = ADDR_W'(col);

    generate
        if (FB_W == 160) begin : g_shift
            // 160 = 128 + 32, so the multiply collapses to two shifts and an add.
            assign row_base = (row_ext << 7) + (row_ext << 5);
        end else begin : g_mul
            assign row_base = ADDR_W'(row_ext * ADDR_W'(FB_W));
        end
    endgenerate

    assign addr = row_base + col_ext;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates one single-port framebuffer RAM between the scan-out path and a
// pixel writer, and produces the upscaled RGB stream.
//   clk, reset              : pixel clock, synchronous active-high reset
//   x, y                    : hcount / vcount from the timing generator
//   video_on, hsync_in, vsync_in : timing-generator outputs aligned with x/y
//   rgb, hsync, vsync       : display outputs, all one cycle behind x/y
//   frame_start             : one-cycle pulse at the start of vertical blank
//   bus                     : writer channel and RAM command/data bus
// Each stored pixel covers a (1<<SCALE_LOG2)-square block of screen pixels, so
// only one RAM read per group is needed; every other cycle is free for writes.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int SCALE_LOG2 = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [COORD_W-1:0]  x,
    input  logic [COORD_W-1:0]  y,
    input  logic                video_on,
    input  logic                hsync_in,
    input  logic                vsync_in,
    output logic [COLOR_W-1:0]  rgb,
    output logic                hsync,
    output logic                vsync,
    output logic                frame_start,
    vga_fb_arbiter_if.master    bus
);

    localparam int GRP         = 1 << SCALE_LOG2;
    localparam int DEPTH       = FB_W * FB_H;
    // Group g is fetched at x = GRP*g - (GRP-1); the last group reads before this.
    localparam int LAST_SLOT_X = H_ACTIVE - GRP + 1;
    // Group 0 of the next line is fetched late in the current line's blanking.
    localparam int PREFETCH_X  = H_TOTAL - GRP + 1;
    localparam int XR_W        = COORD_W + 1;

    logic [COORD_W-1:0] next_line;
    logic [XR_W-1:0]    x_round;
    logic               disp_slot;
    logic [ROW_W-1:0]   rd_row;
    logic [COL_W-1:0]   rd_col;
    logic [ADDR_W-1:0]  rd_addr;

    logic               wr_ready_c;
    logic               wr_xfer;
    logic               wr_in_range;

    port_state_t        state;
    port_state_t        state_nxt;

    logic               en_nxt;
    logic               we_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [COLOR_W-1:0] wdata_nxt;

    logic               mem_en_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [COLOR_W-1:0] mem_wdata_q;

    logic               rd_vld_p1;
    logic [COLOR_W-1:0] disp_word;

    // ---- stage 0: display slot detection and read address ----
    always_comb begin
        next_line = (y == COORD_W'(V_TOTAL - 1)) ? '0 : y + COORD_W'(1);
        x_round   = {1'b0, x} + XR_W'(GRP - 1);

        disp_slot = ((x[SCALE_LOG2-1:0] == SCALE_LOG2'(1)) &&
                     (x < COORD_W'(LAST_SLOT_X)) &&
                     (y < COORD_W'(V_ACTIVE))) ||
                    ((x == COORD_W'(PREFETCH_X)) &&
                     (next_line < COORD_W'(V_ACTIVE)));

        if (x == COORD_W'(PREFETCH_X)) begin
            rd_row = ROW_W'(next_line >> SCALE_LOG2);
            rd_col = '0;
        end else begin
            rd_row = ROW_W'(y >> SCALE_LOG2);
            rd_col = COL_W'(x_round >> SCALE_LOG2);
        end
    end

    fb_addr_calc #(
        .FB_W (FB_W)
    ) u_addr_calc (
        .row  (rd_row),
        .col  (rd_col),
        .addr (rd_addr)
    );

    // The writer only ever loses cycles to display slots.
    assign wr_ready_c   = !disp_slot && !reset;
    assign bus.wr_ready = wr_ready_c;
    assign wr_xfer      = bus.wr_valid && wr_ready_c;
    assign wr_in_range  = bus.wr_addr < ADDR_W'(DEPTH);

    // ---- stage 0 -> port: state register and registered RAM command ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state       <= state_nxt;
            mem_en_q    <= en_nxt;
            mem_we_q    <= we_nxt;
            mem_addr_q  <= addr_nxt;
            mem_wdata_q <= wdata_nxt;
        end
    end

    // Display reads always win; out-of-range writes are accepted but dropped.
    always_comb begin
        state_nxt = IDLE;
        if (disp_slot) begin
            state_nxt = DISP_RD;
        end else if (wr_xfer && wr_in_range) begin
            state_nxt = WRITE;
        end
    end

    // Idle cycles keep the last address/data to avoid needless bus toggling.
    always_comb begin
        en_nxt    = 1'b0;
        we_nxt    = 1'b0;
        addr_nxt  = mem_addr_q;
        wdata_nxt = mem_wdata_q;
        unique case (state_nxt)
            DISP_RD: begin
                en_nxt   = 1'b1;
                addr_nxt = rd_addr;
            end
            WRITE: begin
                en_nxt    = 1'b1;
                we_nxt    = 1'b1;
                addr_nxt  = bus.wr_addr;
                wdata_nxt = bus.wr_data;
            end
            default: begin
            end
        endcase
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // ---- port -> p1: RAM latency, word capture and display registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_p1   <= 1'b0;
            disp_word   <= '0;
            rgb         <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            rd_vld_p1 <= (state == DISP_RD);
            if (rd_vld_p1) begin
                disp_word <= bus.mem_rdata;
            end
            rgb         <= video_on ? disp_word : '0;
            hsync       <= hsync_in;
            vsync       <= vsync_in;
            frame_start <= (x == '0) && (y == COORD_W'(V_ACTIVE));
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: reset values, a table of single-cycle
// arbitration vectors, hand sequences for the multi-cycle corners, and random
// writer traffic over continuous scanlines against a behavioural model.
module tb_vga_fb_arbiter;

    logic        clk;
    logic        reset;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [11:0] rgb;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    vga_fb_arbiter_if bus();

    vga_fb_arbiter #(
        .FB_W       (160),
        .FB_H       (120),
        .SCALE_LOG2 (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .video_on    (video_on),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .rgb         (rgb),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start),
        .bus         (bus)
    );

    int total;
    int bad;
    int cur_x;
    int cur_y;

    // RAM with 1-cycle synchronous read; ram_clear reloads data[a] = a[11:0].
    logic [11:0] ram [0:19199];
    logic        ram_clear;

    // Behavioural memory and the word each fetch returned, per address.
    logic [11:0] model_mem [0:19199];
    logic [11:0] snap      [0:19199];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 19200; i++) ram[i] <= 12'(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                if (bus.mem_addr < 15'd19200) ram[bus.mem_addr] <= bus.mem_wdata;
            end else begin
                bus.mem_rdata <= (bus.mem_addr < 15'd19200) ? ram[bus.mem_addr] : 12'h000;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    typedef struct {
        string nm;
        int    xi;
        int    yi;
        bit    v;
        int    a;
        int    d;
        bit    e_rdy;
        bit    e_en;
        bit    e_we;
        int    e_addr;
        int    e_wd;
    } vec_t;

    function automatic vec_t mk(string nm, int xi, int yi, bit v, int a, int d,
                                bit e_rdy, bit e_en, bit e_we, int e_addr, int e_wd);
        vec_t r;
        r.nm = nm; r.xi = xi; r.yi = yi; r.v = v; r.a = a; r.d = d;
        r.e_rdy = e_rdy; r.e_en = e_en; r.e_we = e_we; r.e_addr = e_addr; r.e_wd = e_wd;
        return r;
    endfunction

    // Slot rule and read address straight from the raster arithmetic.
    function automatic bit slot_m(int xi, int yi);
        int nl;
        nl = (yi == 524) ? 0 : yi + 1;
        return ((xi % 4) == 1 && xi < 637 && yi < 480) || (xi == 797 && nl < 480);
    endfunction

    function automatic int raddr_m(int xi, int yi);
        int nl;
        nl = (yi == 524) ? 0 : yi + 1;
        if (xi == 797) return (nl / 4) * 160;
        return (yi / 4) * 160 + (xi + 3) / 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got 0x%0h want 0x%0h (x=%0d y=%0d)", nm, act, exp, cur_x, cur_y);
        end
    endtask

    task automatic drive(input int xi, input int yi, input bit v, input int a, input int d);
        cur_x = xi;
        cur_y = yi;
        x = 10'(xi);
        y = 10'(yi);
        video_on = (xi < 640) && (yi < 480);
        hsync_in = !(xi >= 656 && xi < 752);
        vsync_in = !(yi >= 490 && yi < 492);
        bus.wr_valid = v;
        bus.wr_addr = 15'(a);
        bus.wr_data = 12'(d);
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int sx, input int sy, input int n);
        int cx, cy, a, d, ea, ed, ergb;
        bit v, s, e_en, e_we, ehs, evs, efs;
        cx = sx;
        cy = sy;
        for (int k = 0; k < n; k++) begin
            v = ($urandom_range(0, 1) == 1);
            a = ($urandom_range(0, 7) == 0) ? 19200 + int'($urandom_range(0, 13567))
                                             : int'($urandom_range(0, 19199));
            d = int'($urandom_range(0, 4095));
            drive(cx, cy, v, a, d);
            s = slot_m(cx, cy);
            chk("rnd_ready", bus.wr_ready, !s);
            e_en = 1'b0; e_we = 1'b0; ea = 0; ed = 0;
            if (s) begin
                e_en = 1'b1;
                ea = raddr_m(cx, cy);
                snap[ea] = model_mem[ea];
            end else if (v && a < 19200) begin
                e_en = 1'b1; e_we = 1'b1; ea = a; ed = d;
            end
            ergb = (cx < 640 && cy < 480) ? int'(snap[(cy / 4) * 160 + cx / 4]) : 0;
            ehs = hsync_in;
            evs = vsync_in;
            efs = (cx == 0 && cy == 480);
            tick;
            chk("rnd_en", bus.mem_en, e_en);
            chk("rnd_we", bus.mem_we, e_we);
            if (e_en) chk("rnd_addr", bus.mem_addr, ea);
            if (e_we) begin
                chk("rnd_wdata", bus.mem_wdata, ed);
                model_mem[ea] = 12'(ed);
            end
            chk("rnd_rgb", rgb, ergb);
            chk("rnd_hsync", hsync, ehs);
            chk("rnd_vsync", vsync, evs);
            chk("rnd_fstart", frame_start, efs);
            cx++;
            if (cx == 800) begin
                cx = 0;
                cy = (cy == 524) ? 0 : cy + 1;
            end
        end
    endtask

    vec_t tbl[14];

    initial begin
        int cx, cy;
        int fs_cnt, fs_bad, rgb_nz, sync_bad;
        bit ehs, evs, efs, blank;

        total = 0;
        bad = 0;
        for (int i = 0; i < 19200; i++) begin
            model_mem[i] = 12'(i);
            snap[i] = 12'(i);
        end

        tbl[0]  = mk("slot_x1",    1,   0,   1'b0, 0,     0,     1'b0, 1'b1, 1'b0, 1,     0);
        tbl[1]  = mk("last_grp",   633, 479, 1'b1, 50,    'h123, 1'b0, 1'b1, 1'b0, 19199, 0);
        tbl[2]  = mk("x637_free",  637, 0,   1'b1, 200,   'h456, 1'b1, 1'b1, 1'b1, 200,   'h456);
        tbl[3]  = mk("wrap_rd",    797, 524, 1'b1, 5,     'h001, 1'b0, 1'b1, 1'b0, 0,     0);
        tbl[4]  = mk("no_rd_480",  797, 479, 1'b0, 0,     0,     1'b1, 1'b0, 1'b0, 0,     0);
        tbl[5]  = mk("next_row",   797, 3,   1'b0, 0,     0,     1'b0, 1'b1, 1'b0, 160,   0);
        tbl[6]  = mk("row1_col2",  5,   4,   1'b0, 0,     0,     1'b0, 1'b1, 1'b0, 162,   0);
        tbl[7]  = mk("wr_x2",      2,   10,  1'b1, 100,   'hABC, 1'b1, 1'b1, 1'b1, 100,   'hABC);
        tbl[8]  = mk("oob_wr",     700, 200, 1'b1, 19200, 'h777, 1'b1, 1'b0, 1'b0, 0,     0);
        tbl[9]  = mk("top_wr",     700, 200, 1'b1, 19199, 'h5A5, 1'b1, 1'b1, 1'b1, 19199, 'h5A5);
        tbl[10] = mk("idle",       0,   480, 1'b0, 0,     0,     1'b1, 1'b0, 1'b0, 0,     0);
        tbl[11] = mk("x1_blank",   1,   480, 1'b1, 7,     'h009, 1'b1, 1'b1, 1'b1, 7,     'h009);
        tbl[12] = mk("mid_rd",     629, 119, 1'b0, 0,     0,     1'b0, 1'b1, 1'b0, 4798,  0);
        tbl[13] = mk("oob_max",    798, 10,  1'b1, 32767, 'hFFF, 1'b1, 1'b0, 1'b0, 0,     0);

        // Reset: outputs at their reset values, writer blocked.
        reset = 1'b1;
        ram_clear = 1'b1;
        drive(700, 490, 1'b1, 5, 5);
        chk("rst_ready", bus.wr_ready, 0);
        tick; tick; tick;
        chk("rst_en", bus.mem_en, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_fstart", frame_start, 0);
        reset = 1'b0;
        ram_clear = 1'b0;

        // Prefetch of row 0 at the end of the last line.
        drive(797, 524, 1'b0, 0, 0);
        chk("wrap_ready", bus.wr_ready, 0);
        tick;
        chk("wrap_en", bus.mem_en, 1);
        chk("wrap_we", bus.mem_we, 0);
        chk("wrap_addr", bus.mem_addr, 0);

        // Line 8 shows stored row 2: 320 then 321.
        cx = 790; cy = 7;
        for (int k = 0; k < 30; k++) begin
            drive(cx, cy, 1'b0, 0, 0);
            tick;
            if (cy == 8 && cx < 8) chk("line8_rgb", rgb, 320 + cx / 4);
            cx++;
            if (cx == 800) begin cx = 0; cy++; end
        end

        run_random(780, 5, 1700);
        run_random(780, 523, 1700);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].xi, tbl[i].yi, tbl[i].v, tbl[i].a, tbl[i].d);
            chk({tbl[i].nm, "_ready"}, bus.wr_ready, tbl[i].e_rdy);
            tick;
            chk({tbl[i].nm, "_en"}, bus.mem_en, tbl[i].e_en);
            chk({tbl[i].nm, "_we"}, bus.mem_we, tbl[i].e_we);
            if (tbl[i].e_en) chk({tbl[i].nm, "_addr"}, bus.mem_addr, tbl[i].e_addr);
            if (tbl[i].e_we) chk({tbl[i].nm, "_wdata"}, bus.mem_wdata, tbl[i].e_wd);
        end

        // Writer held at a display slot: refused at x=1, taken at x=2, one write.
        drive(1, 10, 1'b1, 100, 'hABC);
        chk("hold_ready_x1", bus.wr_ready, 0);
        tick;
        chk("hold_rd_en", bus.mem_en, 1);
        chk("hold_rd_we", bus.mem_we, 0);
        chk("hold_rd_addr", bus.mem_addr, 321);
        drive(2, 10, 1'b1, 100, 'hABC);
        chk("hold_ready_x2", bus.wr_ready, 1);
        tick;
        chk("hold_wr_en", bus.mem_en, 1);
        chk("hold_wr_we", bus.mem_we, 1);
        chk("hold_wr_addr", bus.mem_addr, 100);
        chk("hold_wr_data", bus.mem_wdata, 'hABC);
        drive(3, 10, 1'b0, 100, 'hABC);
        tick;
        chk("hold_after1_we", bus.mem_we, 0);
        drive(4, 10, 1'b0, 100, 'hABC);
        tick;
        chk("hold_after2_we", bus.mem_we, 0);

        // Out-of-range write in blanking is consumed without touching RAM.
        drive(700, 490, 1'b1, 19200, 'h321);
        chk("oob_ready", bus.wr_ready, 1);
        tick;
        chk("oob_en1", bus.mem_en, 0);
        drive(701, 490, 1'b0, 0, 0);
        tick;
        chk("oob_en2", bus.mem_en, 0);

        // Into vertical blank: one frame_start, black screen, delayed syncs.
        fs_cnt = 0; fs_bad = 0; rgb_nz = 0; sync_bad = 0;
        cx = 790; cy = 479;
        for (int k = 0; k < 9600; k++) begin
            drive(cx, cy, 1'b0, 0, 0);
            ehs = hsync_in;
            evs = vsync_in;
            efs = (cx == 0 && cy == 480);
            blank = (cy >= 480);
            tick;
            if (frame_start === 1'b1) fs_cnt++;
            if (frame_start !== efs) fs_bad++;
            if (blank && rgb !== 12'h000) rgb_nz++;
            if (hsync !== ehs || vsync !== evs) sync_bad++;
            cx++;
            if (cx == 800) begin cx = 0; cy++; end
        end
        chk("fstart_count", fs_cnt, 1);
        chk("fstart_pos", fs_bad, 0);
        chk("vblank_rgb", rgb_nz, 0);
        chk("sync_delay", sync_bad, 0);

        // One-cycle reset at x=300 of line 100.
        ram_clear = 1'b1;
        drive(700, 490, 1'b0, 0, 0);
        tick;
        ram_clear = 1'b0;
        for (int k = 280; k <= 310; k++) begin
            if (k == 300) reset = 1'b1;
            drive(k, 100, 1'b0, 0, 0);
            if (k == 300) chk("midrst_ready", bus.wr_ready, 0);
            if (k == 301) chk("postrst_ready", bus.wr_ready, 0);
            tick;
            reset = 1'b0;
            if (k == 300) begin
                chk("midrst_en", bus.mem_en, 0);
                chk("midrst_we", bus.mem_we, 0);
                chk("midrst_addr", bus.mem_addr, 0);
                chk("midrst_wdata", bus.mem_wdata, 0);
                chk("midrst_rgb", rgb, 0);
                chk("midrst_hsync", hsync, 1);
                chk("midrst_vsync", vsync, 1);
                chk("midrst_fstart", frame_start, 0);
            end
            if (k == 301) begin
                chk("postrst_en", bus.mem_en, 1);
                chk("postrst_we", bus.mem_we, 0);
                chk("postrst_addr", bus.mem_addr, 4076);
            end
            if (k >= 296 && k <= 299) chk("prerst_rgb", rgb, 4074);
            if (k >= 301 && k <= 303) chk("postrst_black", rgb, 0);
            if (k >= 304 && k <= 307) chk("postrst_rgb", rgb, 4076);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameters: FB_W=160 (framebuffer columns), FB_H=120 (framebuffer rows), SCALE_LOG2=2 (each stored pixel covers a 4x4 block of screen pixels).
REQ-002 SHALL have ports: clk input 1, system pixel clock; all logic on its rising edge.
REQ-003 SHALL have ports: reset input 1, synchronous, active-high.
REQ-004 x input 10 / y input 10: current hcount/vcount from the timing generator (0..799 / 0..524).
REQ-005 video_on input 1, hsync_in input 1, vsync_in input 1: timing-generator outputs, same cycle as x/y.
REQ-006 wr_valid input 1, wr_addr input 15, wr_data input 12: writer request; wr_ready output 1.
REQ-007 mem_en output 1, mem_we output 1, mem_addr output 15, mem_wdata output 12, mem_rdata input 12: single-port RAM (RAM has 1-cycle synchronous read).
REQ-008 rgb output 12, hsync output 1, vsync output 1: display outputs; frame_start output 1: one-cycle pulse.

Function
REQ-009 SHALL drive all mem_* outputs from registers; a port operation decided in cycle N appears on the port in cycle N+1.
REQ-010 SHALL define display slot in cycle N when (x[1:0]==1 && x<637 && y<480) or (x==797 && next_line<480), with next_line = (y==524)?0:y+1.
REQ-011 A display slot SHALL issue a read: mem_en=1, mem_we=0, mem_addr=(row*160)+col, with row=y>>2 and col=(x+3)>>2; for x==797, row=next_line>>2 and col=0.
REQ-012 SHALL assert wr_ready combinationally when no display slot exists in the current cycle and reset is low; a transfer occurs when wr_valid && wr_ready at the clock edge.
REQ-013 An accepted transfer with wr_addr<19200 SHALL produce mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data in the next cycle.
REQ-014 An accepted transfer with wr_addr>=19200 SHALL be consumed with no RAM access.
REQ-015 A cycle with no slot and no transfer SHALL produce mem_en=0, mem_we=0 in the next cycle.
REQ-016 Port state machine SHALL have states IDLE, DISP_RD, WRITE, held as a registered port-state, with next state chosen per cycle in priority order DISP_RD > WRITE > IDLE.
REQ-017 SHALL track a one-cycle RAM read-latency stage: mem_rdata is captured into disp_word in the cycle after a DISP_RD port cycle, i.e. at the edge ending x==4g-1.
REQ-018 SHALL keep disp_word for group g stable over x=4g..4g+3.
REQ-019 SHALL register rgb <= video_on ? disp_word : 0, giving 1-cycle latency from x to the matching rgb pixel.
REQ-020 SHALL delay hsync and vsync by one register from hsync_in and vsync_in so they align with rgb.
REQ-021 SHALL pulse frame_start for one cycle in the cycle after x==0 && y==480 (start of vertical blank).
REQ-022 Display reads SHALL never be delayed or dropped; writer throughput SHALL be at least 3 of every 4 cycles in active video and every cycle in blanking, except x==797.
REQ-023 Address arithmetic SHALL be 15-bit unsigned, computed as row*160 = (row<<7)+(row<<5); the maximum address is 19199.

Reset
REQ-024 While reset is high: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rgb=0, hsync=1, vsync=1, frame_start=0, disp_word=0, state=IDLE, wr_ready=0.
REQ-025 Reset asserted mid-line SHALL discard any in-flight read or write; after release the first pixel group is valid from the next slot, and the pixels before it show 0.

Structure
REQ-026 Shared package vga_fb_pkg SHALL hold: H_TOTAL=800, H_ACTIVE=640, V_TOTAL=525, V_ACTIVE=480, FB_DEPTH=19200, address/color widths, and the port-state encoding.
REQ-027 One sub-module fb_addr_calc (row, col -> 15-bit address, combinational) SHALL be instantiated once.

Verification
REQ-028 Run reset, then x=797 with y=524 -> the next cycle shows mem_en=1, mem_we=0, mem_addr=0, and wr_ready=0 during x=797.
REQ-029 Use RAM model data[a]=a[11:0]; at line y=8 -> rgb=320 for x=0..3 (each appearing one cycle later) and rgb=321 for x=4..7.
REQ-030 Hold wr_valid=1 with wr_addr=100, wr_data=0xABC at x=1, y=10 -> wr_ready=0 at x=1, then accepted at x=2 and WRITE on the port at x=3, exactly one write.
REQ-031 Send wr_addr=19200 during blanking -> accepted in one cycle and mem_en stays 0.
REQ-032 Step to x=0, y=480 -> frame_start=1 for exactly one cycle; rgb=0 throughout vertical blank; hsync/vsync equal hsync_in/vsync_in delayed 1 cycle.
REQ-033 Assert reset for 1 cycle at x=300, y=100 -> all outputs take REQ-024 values, and the display read at x=301 is issued normally.
